// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one req/gnt/rvalid memory port between the fetch stage (instr_*)
//   and the load/store unit (data_*). Data wins arbitration by default; the
//   fetch side is promoted after STARVE_LIMIT consecutive data grants taken
//   while it was waiting. A command stalled by mem_gnt_i=0 is locked to its
//   requester until accepted. Every accepted transaction is recorded in an
//   in-order ID FIFO so that each response is routed back to its issuer.
//   Fetch responses outstanding at a PC redirect are consumed silently.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   instr_req_i/addr_i            fetch read request
//   instr_gnt_o                   fetch request accepted this cycle
//   instr_rvalid_o/rdata_o/err_o  fetch response
//   instr_flush_i                 PC redirect, drop outstanding fetch responses
//   data_req_i/we_i/be_i/addr_i/wdata_i   LSU request
//   data_gnt_o                    LSU request accepted this cycle
//   data_rvalid_o/rdata_o/err_o   LSU response
//   mem_req_o/we_o/be_o/addr_o/wdata_o    shared memory command
//   mem_gnt_i                     memory accepts command
//   mem_rvalid_i/rdata_i/err_i    in-order memory response
//   outstanding_o                 live in-flight transaction count
//   protocol_err_o                sticky, response seen with nothing in flight
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int MAX_OUTSTANDING = 2,   // 1..4
   parameter int STARVE_LIMIT    = 4
) (
   input  logic        clk,
   input  logic        rst,
   // fetch side
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        instr_flush_i,
   // LSU side
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   // memory side
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   // status
   output logic [2:0]  outstanding_o,
   output logic        protocol_err_o
);

   typedef enum logic {
      REQ_INSTR = 1'b0,
      REQ_DATA  = 1'b1
   } req_id_e;

   localparam int PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [PTR_W-1:0]    LAST_IDX   = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
   localparam logic [2:0]          COUNT_MAX  = 3'(MAX_OUTSTANDING);

   // ID FIFO storage and control
   req_id_e             r_fifo_id   [MAX_OUTSTANDING];
   logic                r_fifo_disc [MAX_OUTSTANDING];
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [2:0]          r_count;

   // arbitration state
   logic [STARVE_W-1:0] r_starve_cnt;
   logic                r_lock_valid;
   req_id_e             r_lock_id;
   logic                r_protocol_err;

   req_id_e             w_winner;
   logic                w_win_req;
   logic                w_retire;
   logic                w_accept;
   req_id_e             w_head_id;
   logic                w_head_disc;
   logic                w_instr_rvalid;
   logic                w_data_rvalid;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_IDX) ? '0 : p + 1'b1;
   endfunction

   // ---------------------------------------------------------------------------
   // Arbitration: a stalled command keeps its requester; otherwise data wins
   // unless the fetch side has waited through STARVE_LIMIT data grants.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the block can leave it unassigned and infer a latch.
      w_winner = REQ_DATA;
      if (r_lock_valid) begin
         w_winner = r_lock_id;
      end else if (instr_req_i && (r_starve_cnt == STARVE_MAX)) begin
         w_winner = REQ_INSTR;
      end else if (instr_req_i && !data_req_i) begin
         w_winner = REQ_INSTR;
      end
   end

   assign w_win_req = (w_winner == REQ_DATA) ? data_req_i : instr_req_i;

   // A retiring response frees its slot in the same cycle, so a full FIFO
   // can still accept a new command when mem_rvalid_i is high.
   assign w_retire  = mem_rvalid_i && (r_count != 3'd0);
   assign mem_req_o = w_win_req && ((r_count < COUNT_MAX) || w_retire);
   assign w_accept  = mem_req_o && mem_gnt_i;

   assign instr_gnt_o = w_accept && (w_winner == REQ_INSTR);
   assign data_gnt_o  = w_accept && (w_winner == REQ_DATA);

   // Command mux; all-zero when the winner has nothing to send.
   always_comb begin
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_addr_o  = 32'h0;
      mem_wdata_o = 32'h0;
      if (w_win_req) begin
         if (w_winner == REQ_DATA) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
         end else begin
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_addr_i;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Response routing from the FIFO head. A flush in the same cycle as the
   // head retires already counts as discarding it.
   // ---------------------------------------------------------------------------
   assign w_head_id   = r_fifo_id[r_rd_ptr];
   assign w_head_disc = r_fifo_disc[r_rd_ptr] || instr_flush_i;

   assign w_data_rvalid  = w_retire && (w_head_id == REQ_DATA);
   assign w_instr_rvalid = w_retire && (w_head_id == REQ_INSTR) && !w_head_disc;

   assign data_rvalid_o  = w_data_rvalid;
   assign data_rdata_o   = w_data_rvalid ? mem_rdata_i : 32'h0;
   assign data_err_o     = w_data_rvalid && mem_err_i;
   assign instr_rvalid_o = w_instr_rvalid;
   assign instr_rdata_o  = w_instr_rvalid ? mem_rdata_i : 32'h0;
   assign instr_err_o    = w_instr_rvalid && mem_err_i;

   assign outstanding_o  = r_count;
   assign protocol_err_o = r_protocol_err;

   // ---------------------------------------------------------------------------
   // FIFO payload. Entries are only meaningful between rd and wr pointers, so
   // the array needs no reset; the push is written after the flush loop so a
   // fetch accepted alongside a flush keeps discard=0.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: storage arrays are deliberately left out of reset; only the
      // pointers and count that qualify them are reset.
      if (instr_flush_i) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (r_fifo_id[i] == REQ_INSTR) begin
               r_fifo_disc[i] <= 1'b1;
            end
         end
      end
      if (w_accept) begin
         r_fifo_id[r_wr_ptr]   <= w_winner;
         r_fifo_disc[r_wr_ptr] <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Control state
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values of the others.
      if (rst) begin
         r_rd_ptr       <= '0;
         r_wr_ptr       <= '0;
         r_count        <= 3'd0;
         r_starve_cnt   <= '0;
         r_lock_valid   <= 1'b0;
         r_lock_id      <= REQ_DATA;
         r_protocol_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_retire) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         r_count <= r_count + {2'b00, w_accept} - {2'b00, w_retire};

         // Counter saturates so the promotion threshold cannot be skipped.
         if (instr_gnt_o) begin
            r_starve_cnt <= '0;
         end else if (data_gnt_o && instr_req_i && (r_starve_cnt != STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
         end

         // Latch the requester of a stalled command; hold until accepted.
         if (w_accept) begin
            r_lock_valid <= 1'b0;
         end else if (mem_req_o) begin
            r_lock_valid <= 1'b1;
            r_lock_id    <= w_winner;
         end

         if (mem_rvalid_i && (r_count == 3'd0)) begin
            r_protocol_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed scenarios for each arbiter feature, followed by a randomized run
//   checked against a queue-based reference model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int MAX   = 2;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        instr_err_o;
   logic        instr_flush_i;
   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        data_err_o;
   logic        mem_req_o;
   logic        mem_gnt_i;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        mem_err_i;
   logic [2:0]  outstanding_o;
   logic        protocol_err_o;

   int n_checks = 0;
   int n_errs   = 0;

   typedef struct {
      bit is_data;
      bit disc;
   } ent_t;

   mem_port_arbiter #(
      .MAX_OUTSTANDING (MAX),
      .STARVE_LIMIT    (LIMIT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .instr_req_i    (instr_req_i),
      .instr_addr_i   (instr_addr_i),
      .instr_gnt_o    (instr_gnt_o),
      .instr_rvalid_o (instr_rvalid_o),
      .instr_rdata_o  (instr_rdata_o),
      .instr_err_o    (instr_err_o),
      .instr_flush_i  (instr_flush_i),
      .data_req_i     (data_req_i),
      .data_we_i      (data_we_i),
      .data_be_i      (data_be_i),
      .data_addr_i    (data_addr_i),
      .data_wdata_i   (data_wdata_i),
      .data_gnt_o     (data_gnt_o),
      .data_rvalid_o  (data_rvalid_o),
      .data_rdata_o   (data_rdata_o),
      .data_err_o     (data_err_o),
      .mem_req_o      (mem_req_o),
      .mem_gnt_i      (mem_gnt_i),
      .mem_we_o       (mem_we_o),
      .mem_be_o       (mem_be_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rdata_i    (mem_rdata_i),
      .mem_err_i      (mem_err_i),
      .outstanding_o  (outstanding_o),
      .protocol_err_o (protocol_err_o)
   );

   always #5 clk = ~clk;

   // inputs change 1 time unit after the rising edge, outputs are sampled on
   // the falling edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      instr_req_i   = 1'b0;
      instr_addr_i  = 32'h0;
      instr_flush_i = 1'b0;
      data_req_i    = 1'b0;
      data_we_i     = 1'b0;
      data_be_i     = 4'h0;
      data_addr_i   = 32'h0;
      data_wdata_i  = 32'h0;
      mem_gnt_i     = 1'b0;
      mem_rvalid_i  = 1'b0;
      mem_rdata_i   = 32'h0;
      mem_err_i     = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      for (int p = 0; p < 2; p++) begin
         mid();
         n_checks++; if (outstanding_o !== 3'd0) begin n_errs++; $display("FAIL reset_outstanding[%0d]: got %0d exp 0", p, outstanding_o); end
         n_checks++; if (protocol_err_o !== 1'b0) begin n_errs++; $display("FAIL reset_perr[%0d]: got %b exp 0", p, protocol_err_o); end
         n_checks++; if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 5'b0) begin
            n_errs++; $display("FAIL reset_handshake[%0d]: got %b exp 00000", p, {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o});
         end
         n_checks++; if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== 69'h0) begin
            n_errs++; $display("FAIL reset_cmd[%0d]: got %h exp 0", p, {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o});
         end
         n_checks++; if ({instr_rdata_o, instr_err_o, data_rdata_o, data_err_o} !== 66'h0) begin
            n_errs++; $display("FAIL reset_resp[%0d]: got %h exp 0", p, {instr_rdata_o, instr_err_o, data_rdata_o, data_err_o});
         end
         rst = 1'b0;
         tick();
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_instr_stream();
      apply_reset();
      mem_gnt_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         instr_req_i  = (k < 3);
         instr_addr_i = (k < 3) ? 32'h100 + 32'(4 * k) : 32'h0;
         mem_rvalid_i = (k > 0);
         mem_rdata_i  = 32'hA000 + 32'(k);
         mem_err_i    = (k == 2);
         mid();
         if (k < 3) begin
            n_checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin n_errs++; $display("FAIL istream_gnt[%0d]: got %b exp 10", k, {instr_gnt_o, data_gnt_o}); end
            n_checks++; if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b0, 4'hF, 32'h100 + 32'(4 * k), 32'h0}) begin
               n_errs++; $display("FAIL istream_cmd[%0d]: got addr %h be %h we %b", k, mem_addr_o, mem_be_o, mem_we_o);
            end
         end
         if (k > 0) begin
            n_checks++; if ({instr_rvalid_o, instr_rdata_o, instr_err_o} !== {1'b1, 32'hA000 + 32'(k), (k == 2)}) begin
               n_errs++; $display("FAIL istream_resp[%0d]: got v=%b d=%h e=%b exp d=%h", k, instr_rvalid_o, instr_rdata_o, instr_err_o, 32'hA000 + 32'(k));
            end
         end
         n_checks++; if (outstanding_o !== ((k > 0) ? 3'd1 : 3'd0)) begin n_errs++; $display("FAIL istream_outstanding[%0d]: got %0d", k, outstanding_o); end
         tick();
      end
      idle_inputs();
      mid();
      n_checks++; if (outstanding_o !== 3'd0) begin n_errs++; $display("FAIL istream_drain: got %0d exp 0", outstanding_o); end
      tick();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_starvation();
      bit exp_i;
      bit prev_i;
      apply_reset();
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h800;
      data_req_i   = 1'b1;
      data_addr_i  = 32'h4000;
      data_be_i    = 4'h1;
      mem_gnt_i    = 1'b1;
      prev_i       = 1'b0;
      for (int k = 0; k < 10; k++) begin
         exp_i        = ((k % (LIMIT + 1)) == LIMIT);
         mem_rvalid_i = (k > 0);
         mem_rdata_i  = 32'h5000 + 32'(k);
         mid();
         n_checks++; if ({instr_gnt_o, data_gnt_o} !== {exp_i, !exp_i}) begin
            n_errs++; $display("FAIL starve_gnt[%0d]: got i=%b d=%b exp i=%b d=%b", k, instr_gnt_o, data_gnt_o, exp_i, !exp_i);
         end
         if (k > 0) begin
            n_checks++; if ({instr_rvalid_o, data_rvalid_o} !== {prev_i, !prev_i}) begin
               n_errs++; $display("FAIL starve_route[%0d]: got i=%b d=%b exp i=%b d=%b", k, instr_rvalid_o, data_rvalid_o, prev_i, !prev_i);
            end
         end
         prev_i = exp_i;
         tick();
      end
      idle_inputs();
      mem_rvalid_i = 1'b1;
      mid();
      n_checks++; if (instr_rvalid_o !== 1'b1) begin n_errs++; $display("FAIL starve_last_resp: got %b exp 1", instr_rvalid_o); end
      tick();
      idle_inputs();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_lock();
      apply_reset();
      // data stalled for 3 cycles while fetch starts requesting
      data_req_i   = 1'b1;
      data_we_i    = 1'b1;
      data_be_i    = 4'h3;
      data_addr_i  = 32'hD000_0040;
      data_wdata_i = 32'h1234_5678;
      for (int k = 0; k < 4; k++) begin
         instr_req_i  = (k >= 1);
         instr_addr_i = 32'h200;
         mem_gnt_i    = (k == 3);
         mid();
         n_checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'hD000_0040}) begin n_errs++; $display("FAIL lockd_addr[%0d]: got req=%b addr=%h", k, mem_req_o, mem_addr_o); end
         n_checks++; if ({instr_gnt_o, data_gnt_o} !== {1'b0, (k == 3)}) begin n_errs++; $display("FAIL lockd_gnt[%0d]: got i=%b d=%b", k, instr_gnt_o, data_gnt_o); end
         tick();
      end
      data_req_i   = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hCAFE_0001;
      mid();
      n_checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin n_errs++; $display("FAIL lockd_then_instr: got i=%b d=%b exp i=1 d=0", instr_gnt_o, data_gnt_o); end
      n_checks++; if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b0, 4'hF, 32'h200, 32'h0}) begin
         n_errs++; $display("FAIL lockd_instr_cmd: got we=%b be=%h addr=%h wd=%h", mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
      end
      n_checks++; if ({data_rvalid_o, data_rdata_o} !== {1'b1, 32'hCAFE_0001}) begin n_errs++; $display("FAIL lockd_data_resp: got v=%b d=%h", data_rvalid_o, data_rdata_o); end
      tick();
      instr_req_i = 1'b0;
      mem_rdata_i = 32'hCAFE_0002;
      mid();
      n_checks++; if ({instr_rvalid_o, instr_rdata_o} !== {1'b1, 32'hCAFE_0002}) begin n_errs++; $display("FAIL lockd_instr_resp: got v=%b d=%h", instr_rvalid_o, instr_rdata_o); end
      tick();
      idle_inputs();

      // fetch stalled; data arriving afterwards must not steal the port
      for (int k = 0; k < 4; k++) begin
         instr_req_i  = (k <= 2);
         instr_addr_i = 32'h300;
         data_req_i   = (k >= 1);
         data_addr_i  = 32'hD00;
         mem_gnt_i    = (k >= 2);
         mid();
         n_checks++; if (mem_addr_o !== ((k <= 2) ? 32'h300 : 32'hD00)) begin n_errs++; $display("FAIL locki_addr[%0d]: got %h", k, mem_addr_o); end
         n_checks++; if ({instr_gnt_o, data_gnt_o} !== {(k == 2), (k == 3)}) begin n_errs++; $display("FAIL locki_gnt[%0d]: got i=%b d=%b", k, instr_gnt_o, data_gnt_o); end
         tick();
      end
      idle_inputs();
      mem_rvalid_i = 1'b1;
      mid();
      n_checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin n_errs++; $display("FAIL locki_resp0: got i=%b d=%b exp 10", instr_rvalid_o, data_rvalid_o); end
      tick();
      mid();
      n_checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin n_errs++; $display("FAIL locki_resp1: got i=%b d=%b exp 01", instr_rvalid_o, data_rvalid_o); end
      tick();
      idle_inputs();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_outstanding_limit();
      apply_reset();
      data_req_i = 1'b1;
      mem_gnt_i  = 1'b1;
      for (int k = 0; k < 2; k++) begin
         data_addr_i = 32'h10 + 32'(4 * k);
         mid();
         n_checks++; if (data_gnt_o !== 1'b1) begin n_errs++; $display("FAIL limit_fill[%0d]: got %b exp 1", k, data_gnt_o); end
         tick();
      end
      data_addr_i = 32'h18;
      mid();
      n_checks++; if ({mem_req_o, data_gnt_o} !== 2'b00) begin n_errs++; $display("FAIL limit_full: got req=%b gnt=%b exp 00", mem_req_o, data_gnt_o); end
      n_checks++; if (outstanding_o !== 3'(MAX)) begin n_errs++; $display("FAIL limit_count: got %0d exp %0d", outstanding_o, MAX); end
      tick();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h55;
      mem_err_i    = 1'b1;
      mid();
      n_checks++; if ({mem_req_o, data_gnt_o} !== 2'b11) begin n_errs++; $display("FAIL limit_retire_issue: got req=%b gnt=%b exp 11", mem_req_o, data_gnt_o); end
      n_checks++; if ({data_rvalid_o, data_rdata_o, data_err_o} !== {1'b1, 32'h55, 1'b1}) begin
         n_errs++; $display("FAIL limit_resp: got v=%b d=%h e=%b", data_rvalid_o, data_rdata_o, data_err_o);
      end
      tick();
      data_req_i = 1'b0;
      mem_err_i  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         mem_rvalid_i = (k < 2);
         mid();
         n_checks++; if (outstanding_o !== 3'(MAX - k)) begin n_errs++; $display("FAIL limit_drain[%0d]: got %0d exp %0d", k, outstanding_o, MAX - k); end
         tick();
      end
      idle_inputs();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_flush();
      apply_reset();
      instr_req_i = 1'b1;
      mem_gnt_i   = 1'b1;
      for (int k = 0; k < 2; k++) begin
         instr_addr_i = 32'h400 + 32'(4 * k);
         tick();
      end
      instr_req_i   = 1'b0;
      instr_flush_i = 1'b1;
      mid();
      n_checks++; if (outstanding_o !== 3'd2) begin n_errs++; $display("FAIL flush_count: got %0d exp 2", outstanding_o); end
      tick();
      instr_flush_i = 1'b0;
      data_req_i    = 1'b1;
      data_addr_i   = 32'h40;
      for (int k = 0; k < 3; k++) begin
         mem_rvalid_i = 1'b1;
         mid();
         if (k == 0) begin
            n_checks++; if (data_gnt_o !== 1'b1) begin n_errs++; $display("FAIL flush_data_gnt: got %b exp 1", data_gnt_o); end
         end
         n_checks++; if ({instr_rvalid_o, data_rvalid_o} !== {1'b0, (k == 2)}) begin
            n_errs++; $display("FAIL flush_resp[%0d]: got i=%b d=%b exp i=0 d=%b", k, instr_rvalid_o, data_rvalid_o, (k == 2));
         end
         tick();
         data_req_i = 1'b0;
      end
      idle_inputs();

      // flush in the cycle the head retires and a new fetch is granted
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h500;
      mem_gnt_i    = 1'b1;
      tick();
      instr_addr_i  = 32'h504;
      instr_flush_i = 1'b1;
      mem_rvalid_i  = 1'b1;
      mem_rdata_i   = 32'hBAD;
      mid();
      n_checks++; if ({instr_rvalid_o, instr_gnt_o} !== 2'b01) begin n_errs++; $display("FAIL flush_same_cycle: got rv=%b gnt=%b exp 01", instr_rvalid_o, instr_gnt_o); end
      tick();
      instr_flush_i = 1'b0;
      instr_req_i   = 1'b0;
      mem_rdata_i   = 32'h600D;
      mid();
      n_checks++; if ({instr_rvalid_o, instr_rdata_o} !== {1'b1, 32'h600D}) begin n_errs++; $display("FAIL flush_new_kept: got v=%b d=%h", instr_rvalid_o, instr_rdata_o); end
      tick();
      idle_inputs();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_protocol_err();
      apply_reset();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hDEAD;
      mid();
      n_checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin n_errs++; $display("FAIL perr_no_route: got i=%b d=%b exp 00", instr_rvalid_o, data_rvalid_o); end
      tick();
      mem_rvalid_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         mid();
         n_checks++; if ({protocol_err_o, outstanding_o} !== {1'b1, 3'd0}) begin n_errs++; $display("FAIL perr_sticky[%0d]: got perr=%b cnt=%0d", k, protocol_err_o, outstanding_o); end
         tick();
      end
      rst = 1'b1;
      tick();
      mid();
      n_checks++; if (protocol_err_o !== 1'b0) begin n_errs++; $display("FAIL perr_clear: got %b exp 0", protocol_err_o); end
      tick();
      rst = 1'b0;

      // reset with a fetch in flight; its late response is unexpected
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h700;
      mem_gnt_i    = 1'b1;
      tick();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mem_rvalid_i = 1'b1;
      mid();
      n_checks++; if ({outstanding_o, instr_rvalid_o} !== {3'd0, 1'b0}) begin n_errs++; $display("FAIL perr_midrst: got cnt=%0d rv=%b", outstanding_o, instr_rvalid_o); end
      tick();
      mem_rvalid_i = 1'b0;
      mid();
      n_checks++; if (protocol_err_o !== 1'b1) begin n_errs++; $display("FAIL perr_late_resp: got %b exp 1", protocol_err_o); end
      tick();
      apply_reset();
   endtask

   // ---------------------------------------------------------------------------
   // Randomized traffic against a reference model: a queue of in-flight
   // requester tags, a starvation count and the stalled-command owner.
   // ---------------------------------------------------------------------------
   task automatic test_random(input int n_cycles);
      ent_t        q[$];
      ent_t        e;
      int          starve;
      bit          locked, lock_data;
      bit          win_data, win_req, retire, exp_req, exp_ig, exp_dg, exp_irv, exp_drv;
      bit          i_hold, d_hold;
      logic [68:0] exp_cmd;
      apply_reset();
      starve = 0;
      locked = 0;
      lock_data = 0;
      i_hold = 0;
      d_hold = 0;
      for (int c = 0; c < n_cycles; c++) begin
         if (!i_hold) begin
            instr_req_i  = ($urandom_range(0, 2) != 0);
            instr_addr_i = $urandom & 32'hFFFF_FFFC;
         end
         if (!d_hold) begin
            data_req_i   = ($urandom_range(0, 2) != 0);
            data_we_i    = $urandom_range(0, 1);
            data_be_i    = 4'($urandom);
            data_addr_i  = $urandom;
            data_wdata_i = $urandom;
         end
         mem_gnt_i     = ($urandom_range(0, 3) != 0);
         instr_flush_i = ($urandom_range(0, 9) == 0);
         mem_rvalid_i  = (q.size() > 0) && ($urandom_range(0, 2) != 0);
         mem_rdata_i   = $urandom;
         mem_err_i     = $urandom_range(0, 1);

         if (locked)                             win_data = lock_data;
         else if (starve == LIMIT && instr_req_i) win_data = 1'b0;
         else                                    win_data = data_req_i;
         win_req = win_data ? data_req_i : instr_req_i;
         retire  = mem_rvalid_i && (q.size() > 0);
         exp_req = win_req && ((q.size() < MAX) || retire);
         exp_dg  = exp_req && mem_gnt_i && win_data;
         exp_ig  = exp_req && mem_gnt_i && !win_data;
         exp_drv = retire && q[0].is_data;
         exp_irv = retire && !q[0].is_data && !q[0].disc && !instr_flush_i;
         exp_cmd = win_data ? {data_we_i, data_be_i, data_addr_i, data_wdata_i} : {1'b0, 4'hF, instr_addr_i, 32'h0};

         mid();
         n_checks++; if ({mem_req_o, instr_gnt_o, data_gnt_o} !== {exp_req, exp_ig, exp_dg}) begin
            n_errs++; $display("FAIL rnd_arb[%0d]: got req/ig/dg=%b%b%b exp %b%b%b", c, mem_req_o, instr_gnt_o, data_gnt_o, exp_req, exp_ig, exp_dg);
         end
         n_checks++; if ({instr_rvalid_o, data_rvalid_o} !== {exp_irv, exp_drv}) begin
            n_errs++; $display("FAIL rnd_route[%0d]: got i=%b d=%b exp i=%b d=%b", c, instr_rvalid_o, data_rvalid_o, exp_irv, exp_drv);
         end
         n_checks++; if ({outstanding_o, protocol_err_o} !== {3'(q.size()), 1'b0}) begin
            n_errs++; $display("FAIL rnd_status[%0d]: got cnt=%0d perr=%b exp cnt=%0d perr=0", c, outstanding_o, protocol_err_o, q.size());
         end
         if (exp_req) begin
            n_checks++; if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== exp_cmd) begin
               n_errs++; $display("FAIL rnd_cmd[%0d]: got %h exp %h", c, {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, exp_cmd);
            end
         end
         if (exp_drv) begin
            n_checks++; if ({data_rdata_o, data_err_o} !== {mem_rdata_i, mem_err_i}) begin
               n_errs++; $display("FAIL rnd_drdata[%0d]: got %h/%b exp %h/%b", c, data_rdata_o, data_err_o, mem_rdata_i, mem_err_i);
            end
         end
         if (exp_irv) begin
            n_checks++; if ({instr_rdata_o, instr_err_o} !== {mem_rdata_i, mem_err_i}) begin
               n_errs++; $display("FAIL rnd_irdata[%0d]: got %h/%b exp %h/%b", c, instr_rdata_o, instr_err_o, mem_rdata_i, mem_err_i);
            end
         end

         if (instr_flush_i) begin
            foreach (q[j]) if (!q[j].is_data) q[j].disc = 1'b1;
         end
         if (retire) void'(q.pop_front());
         if (exp_req && mem_gnt_i) begin
            e.is_data = win_data;
            e.disc    = 1'b0;
            q.push_back(e);
         end
         if (exp_ig)                                           starve = 0;
         else if (exp_dg && instr_req_i && starve < LIMIT)     starve++;
         if (exp_req && mem_gnt_i) locked = 1'b0;
         else if (exp_req) begin
            locked    = 1'b1;
            lock_data = win_data;
         end
         i_hold = instr_req_i && !exp_ig;
         d_hold = data_req_i && !exp_dg;
         tick();
      end
      idle_inputs();
   endtask

   // ---------------------------------------------------------------------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_instr_stream();
      test_starvation();
      test_lock();
      test_outstanding_limit();
      test_flush();
      test_protocol_err();
      test_random(2000);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
